// File: rtl/xy_router_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : xy_router_rr_if
// Brief    : Valid/ready packet bundle plus status outputs of one XY router.
// Revision : 1.0 - initial release
// ============================================================================
interface xy_router_rr_if #(
   parameter int PORT_N    = 5,
   parameter int PCKT_W    = 12,
   parameter int ERR_CNT_W = 8
);
   logic [PORT_N*PCKT_W-1:0] in_pckt_i;
   logic [PORT_N-1:0]        in_valid_i;
   logic [PORT_N-1:0]        in_ready_o;
   logic [PORT_N*PCKT_W-1:0] out_pckt_o;
   logic [PORT_N-1:0]        out_valid_o;
   logic [PORT_N-1:0]        out_ready_i;
   logic [PORT_N-1:0]        ovrflw_o;
   logic [ERR_CNT_W-1:0]     drop_cnt_o;

   modport slave (
      input  in_pckt_i, in_valid_i, out_ready_i,
      output in_ready_o, out_pckt_o, out_valid_o, ovrflw_o, drop_cnt_o
   );

   modport master (
      output in_pckt_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_pckt_o, out_valid_o, ovrflw_o, drop_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/xy_router_rr.sv
`default_nettype none
// ============================================================================
// Module   : xy_router_rr
// Brief    : Buffered XY mesh router, per-input FIFOs, round-robin outputs.
// Revision : 1.0 - initial release
// ============================================================================
module xy_router_rr #(
   parameter int ROW_N        = 3,
   parameter int COL_M        = 3,
   parameter int ROW_CORD     = 0,
   parameter int COL_CORD     = 0,
   parameter int PCKT_DATA_W  = 8,
   parameter int FIFO_DEPTH_W = 2,
   parameter int PORT_N       = 5,
   parameter int ERR_CNT_W    = 8
) (
   input wire           clk_i,
   input wire           rst_ni,
   xy_router_rr_if.slave bus
);
   localparam int RA_W    = $clog2(ROW_N);
   localparam int CA_W    = $clog2(COL_M);
   localparam int PCKT_W  = PCKT_DATA_W + CA_W + RA_W;
   localparam int c_DEPTH = 2**FIFO_DEPTH_W;
   localparam int c_PTR_W = $clog2(PORT_N);
   localparam int c_SUM_W = ERR_CNT_W + c_PTR_W + 1;

   localparam logic [FIFO_DEPTH_W:0] c_FULL      = (FIFO_DEPTH_W+1)'(c_DEPTH);
   localparam logic [CA_W:0]         c_COL_M     = (CA_W+1)'(COL_M);
   localparam logic [RA_W:0]         c_ROW_N     = (RA_W+1)'(ROW_N);
   localparam logic [CA_W:0]         c_COL_CORD  = (CA_W+1)'(COL_CORD);
   localparam logic [RA_W:0]         c_ROW_CORD  = (RA_W+1)'(ROW_CORD);
   localparam logic [ERR_CNT_W-1:0]  c_CNT_MAX   = {ERR_CNT_W{1'b1}};
   localparam logic [c_PTR_W-1:0]    c_LOCAL     = c_PTR_W'(0);
   localparam logic [c_PTR_W-1:0]    c_LEFT      = c_PTR_W'(1);
   localparam logic [c_PTR_W-1:0]    c_UP        = c_PTR_W'(2);
   localparam logic [c_PTR_W-1:0]    c_RIGHT     = c_PTR_W'(3);
   localparam logic [c_PTR_W-1:0]    c_DOWN      = c_PTR_W'(4);
   localparam logic [c_PTR_W-1:0]    c_LAST_PORT = c_PTR_W'(PORT_N-1);

   logic [PCKT_W-1:0]       r_mem      [PORT_N][c_DEPTH];
   logic [FIFO_DEPTH_W-1:0] r_wptr     [PORT_N];
   logic [FIFO_DEPTH_W-1:0] r_rptr     [PORT_N];
   logic [FIFO_DEPTH_W:0]   r_cnt      [PORT_N];
   logic [PORT_N-1:0]       r_ovrflw;
   logic [ERR_CNT_W-1:0]    r_drop_cnt;
   logic [PCKT_W-1:0]       r_out_pckt [PORT_N];
   logic [PORT_N-1:0]       r_out_valid;
   logic [c_PTR_W-1:0]      r_rr_ptr   [PORT_N];

   logic [PORT_N-1:0]        w_full;
   logic [PORT_N-1:0]        w_empty;
   logic [PORT_N-1:0]        w_push;
   logic [PORT_N-1:0]        w_pop;
   logic [PORT_N-1:0]        w_drop;
   logic [PCKT_W-1:0]        w_head     [PORT_N];
   logic [c_PTR_W-1:0]       w_dst      [PORT_N];
   logic [PORT_N-1:0]        w_req      [PORT_N];
   logic [PORT_N-1:0]        w_load;
   logic [PORT_N-1:0]        w_gnt_vld;
   logic [c_PTR_W-1:0]       w_gnt_idx  [PORT_N];
   logic [c_SUM_W-1:0]       w_drop_sum;
   logic [c_SUM_W-1:0]       w_cnt_sum;
   logic [ERR_CNT_W-1:0]     w_drop_nxt;
   logic [PORT_N*PCKT_W-1:0] w_out_flat;

   // First requester at or after ptr, scanning upward modulo PORT_N; {valid, index}.
   function automatic logic [c_PTR_W:0] rr_pick(input logic [PORT_N-1:0]  req,
                                                 input logic [c_PTR_W-1:0] ptr);
      logic [c_PTR_W:0] res;
      int               idx;
      res = '0;
      for (int k = PORT_N-1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % PORT_N;
         if (req[c_PTR_W'(idx)]) res = {1'b1, c_PTR_W'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      for (int p = 0; p < PORT_N; p++) begin
         w_full[p]  = (r_cnt[p] == c_FULL);
         w_empty[p] = (r_cnt[p] == '0);
         w_push[p]  = bus.in_valid_i[p] && !w_full[p];
         w_head[p]  = r_mem[p][r_rptr[p]];
      end
   end

   // Column resolved before row; out-of-mesh heads are flagged for drop instead.
   always_comb begin
      for (int p = 0; p < PORT_N; p++) begin
         logic [CA_W:0] v_col;
         logic [RA_W:0] v_row;
         v_col     = {1'b0, w_head[p][PCKT_DATA_W +: CA_W]};
         v_row     = {1'b0, w_head[p][PCKT_DATA_W+CA_W +: RA_W]};
         w_drop[p] = 1'b0;
         w_dst[p]  = c_LOCAL;
         if (v_col >= c_COL_M || v_row >= c_ROW_N) begin
            w_drop[p] = !w_empty[p];
         end else if (v_col < c_COL_CORD) begin
            w_dst[p] = c_LEFT;
         end else if (v_col > c_COL_CORD) begin
            w_dst[p] = c_RIGHT;
         end else if (v_row < c_ROW_CORD) begin
            w_dst[p] = c_UP;
         end else if (v_row > c_ROW_CORD) begin
            w_dst[p] = c_DOWN;
         end
      end
   end

   always_comb begin
      for (int o = 0; o < PORT_N; o++) begin
         logic [c_PTR_W:0] v_pick;
         for (int p = 0; p < PORT_N; p++) begin
            w_req[o][p] = !w_empty[p] && !w_drop[p] && (w_dst[p] == c_PTR_W'(o));
         end
         w_load[o]    = !r_out_valid[o] || bus.out_ready_i[o];
         v_pick       = rr_pick(w_req[o], r_rr_ptr[o]);
         w_gnt_vld[o] = v_pick[c_PTR_W];
         w_gnt_idx[o] = v_pick[c_PTR_W-1:0];
      end
   end

   always_comb begin
      for (int p = 0; p < PORT_N; p++) begin
         w_pop[p] = w_drop[p];
         for (int o = 0; o < PORT_N; o++) begin
            if (w_load[o] && w_gnt_vld[o] && w_gnt_idx[o] == c_PTR_W'(p)) w_pop[p] = 1'b1;
         end
      end
   end

   always_comb begin
      w_drop_sum = '0;
      for (int p = 0; p < PORT_N; p++) begin
         w_drop_sum = w_drop_sum + c_SUM_W'(w_drop[p]);
      end
      w_cnt_sum  = c_SUM_W'(r_drop_cnt) + w_drop_sum;
      w_drop_nxt = (w_cnt_sum > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_cnt_sum[ERR_CNT_W-1:0];
   end

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < PORT_N; p++) begin
         if (w_push[p]) r_mem[p][r_wptr[p]] <= bus.in_pckt_i[p*PCKT_W +: PCKT_W];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < PORT_N; p++) begin
            r_wptr[p] <= '0;
            r_rptr[p] <= '0;
            r_cnt[p]  <= '0;
         end
         r_ovrflw   <= '0;
         r_drop_cnt <= '0;
      end else begin
         for (int p = 0; p < PORT_N; p++) begin
            if (w_push[p]) r_wptr[p] <= r_wptr[p] + FIFO_DEPTH_W'(1);
            if (w_pop[p])  r_rptr[p] <= r_rptr[p] + FIFO_DEPTH_W'(1);
            case ({w_push[p], w_pop[p]})
               2'b10:   r_cnt[p] <= r_cnt[p] + (FIFO_DEPTH_W+1)'(1);
               2'b01:   r_cnt[p] <= r_cnt[p] - (FIFO_DEPTH_W+1)'(1);
               default: r_cnt[p] <= r_cnt[p];
            endcase
         end
         r_ovrflw   <= r_ovrflw | (bus.in_valid_i & w_full);
         r_drop_cnt <= w_drop_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int o = 0; o < PORT_N; o++) begin
            r_out_pckt[o] <= '0;
            r_rr_ptr[o]   <= '0;
         end
         r_out_valid <= '0;
      end else begin
         for (int o = 0; o < PORT_N; o++) begin
            if (w_load[o]) begin
               r_out_valid[o] <= w_gnt_vld[o];
               if (w_gnt_vld[o]) begin
                  r_out_pckt[o] <= w_head[w_gnt_idx[o]];
                  r_rr_ptr[o]   <= (w_gnt_idx[o] == c_LAST_PORT) ? '0
                                   : w_gnt_idx[o] + c_PTR_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      w_out_flat = '0;
      for (int o = 0; o < PORT_N; o++) begin
         w_out_flat[o*PCKT_W +: PCKT_W] = r_out_pckt[o];
      end
   end

   assign bus.in_ready_o  = ~w_full;
   assign bus.out_pckt_o  = w_out_flat;
   assign bus.out_valid_o = r_out_valid;
   assign bus.ovrflw_o    = r_ovrflw;
   assign bus.drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xy_router_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_xy_router_rr
// Brief    : Directed bench: 4x4 router at (1,1) and 3x3 router at (0,0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xy_router_rr;
   localparam int c_PN = 5;
   localparam int c_PW = 12;

   logic clk;
   logic rst_n;

   xy_router_rr_if #(.PORT_N(c_PN), .PCKT_W(c_PW), .ERR_CNT_W(8)) bus_a ();
   xy_router_rr_if #(.PORT_N(c_PN), .PCKT_W(c_PW), .ERR_CNT_W(2)) bus_b ();

   xy_router_rr #(
      .ROW_N(4), .COL_M(4), .ROW_CORD(1), .COL_CORD(1),
      .PCKT_DATA_W(8), .FIFO_DEPTH_W(2), .PORT_N(c_PN), .ERR_CNT_W(8)
   ) u_dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_a)
   );

   xy_router_rr #(
      .ROW_N(3), .COL_M(3), .ROW_CORD(0), .COL_CORD(0),
      .PCKT_DATA_W(8), .FIFO_DEPTH_W(2), .PORT_N(c_PN), .ERR_CNT_W(2)
   ) u_dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [c_PW-1:0] mk(input int row, input int col, input logic [7:0] d);
      return {row[1:0], col[1:0], d};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle valid pulse of the same packet on every port in mask.
   task automatic send(input bit sel_b, input logic [c_PN-1:0] mask, input logic [c_PW-1:0] pkt);
      for (int p = 0; p < c_PN; p++) begin
         if (mask[p]) begin
            if (sel_b) bus_b.in_pckt_i[p*c_PW +: c_PW] = pkt;
            else       bus_a.in_pckt_i[p*c_PW +: c_PW] = pkt;
         end
      end
      if (sel_b) bus_b.in_valid_i = mask;
      else       bus_a.in_valid_i = mask;
      tick(1);
      bus_a.in_valid_i = '0;
      bus_b.in_valid_i = '0;
   endtask

   logic [c_PW-1:0] q_out [c_PN][$];
   int              q_cyc3 [$];
   int              cyc = 0;
   bit              b_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int o = 0; o < c_PN; o++) begin
         if (bus_a.out_valid_o[o] === 1'b1 && bus_a.out_ready_i[o] === 1'b1) begin
            q_out[o].push_back(bus_a.out_pckt_o[o*c_PW +: c_PW]);
            if (o == 3) q_cyc3.push_back(cyc);
         end
      end
      if (bus_b.out_valid_o !== '0 && rst_n === 1'b1) b_seen = 1'b1;
   end

   task automatic clear_q();
      for (int o = 0; o < c_PN; o++) q_out[o].delete();
      q_cyc3.delete();
   endtask

   function automatic int q_total();
      int t = 0;
      for (int o = 0; o < c_PN; o++) t += q_out[o].size();
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int              tp   [6] = '{0, 1, 0, 0, 0, 2};
   int              trow [6] = '{1, 3, 0, 1, 2, 2};
   int              tcol [6] = '{3, 1, 1, 1, 0, 2};
   int              texp [6] = '{3, 4, 2, 0, 1, 3};
   logic [c_PW-1:0] pkt;
   logic [c_PW-1:0] obs;
   int              acc;

   initial begin
      rst_n             = 1'b0;
      bus_a.in_pckt_i   = '0;
      bus_a.in_valid_i  = '0;
      bus_a.out_ready_i = '1;
      bus_b.in_pckt_i   = '0;
      bus_b.in_valid_i  = '0;
      bus_b.out_ready_i = '1;
      tick(2);
      check_eq("rst_in_ready",  32'(bus_a.in_ready_o),  32'h1f);
      check_eq("rst_out_valid", 32'(bus_a.out_valid_o), 32'h0);
      check_eq("rst_out_pckt",  32'(|bus_a.out_pckt_o), 32'h0);
      check_eq("rst_ovrflw",    32'(bus_a.ovrflw_o),    32'h0);
      check_eq("rst_drop_a",    32'(bus_a.drop_cnt_o),  32'h0);
      check_eq("rst_drop_b",    32'(bus_b.drop_cnt_o),  32'h0);
      rst_n = 1'b1;
      tick(1);

      // Routing and two-cycle latency through the idle 4x4 router
      for (int i = 0; i < 6; i++) begin
         pkt = mk(trow[i], tcol[i], 8'hA5 ^ 8'(i));
         send(1'b0, c_PN'(1 << tp[i]), pkt);
         check_eq("lat_not_yet", 32'(bus_a.out_valid_o), 32'h0);
         tick(1);
         check_eq("route_valid", 32'(bus_a.out_valid_o), 32'(1 << texp[i]));
         check_eq("route_pckt",  32'(bus_a.out_pckt_o[texp[i]*c_PW +: c_PW]), 32'(pkt));
         tick(1);
      end

      // Three inputs contend for RIGHT: grants must rotate 0,1,2 once per cycle
      clear_q();
      for (int p = 0; p < 3; p++) bus_a.in_pckt_i[p*c_PW +: c_PW] = mk(1, 3, {4'(p), 4'h0});
      bus_a.in_valid_i = 5'b00111;
      tick(1);
      for (int p = 0; p < 3; p++) bus_a.in_pckt_i[p*c_PW +: c_PW] = mk(1, 3, {4'(p), 4'h1});
      tick(1);
      bus_a.in_valid_i = '0;
      tick(8);
      check_eq("rr_count", 32'(q_out[3].size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         obs = (i < q_out[3].size()) ? q_out[3][i] : 12'hFFF;
         check_eq("rr_order", 32'(obs), 32'(mk(1, 3, {4'(i % 3), 4'(i / 3)})));
      end
      for (int i = 1; i < 6; i++) begin
         check_eq("rr_back2back", (i < q_cyc3.size()) ? 32'(q_cyc3[i] - q_cyc3[i-1]) : 32'hFFFF, 32'd1);
      end
      check_eq("rr_other_outs", 32'(q_total() - q_out[3].size()), 32'd0);

      // Backpressure on RIGHT: 1 in the output stage + 4 in the FIFO, then overflow
      clear_q();
      bus_a.out_ready_i[3] = 1'b0;
      acc = 0;
      for (int k = 0; k < 7; k++) begin
         bus_a.in_pckt_i[0 +: c_PW] = mk(1, 3, 8'h10 + 8'(acc));
         bus_a.in_valid_i = 5'b00001;
         if (bus_a.in_ready_o[0]) acc++;
         tick(1);
      end
      bus_a.in_valid_i = '0;
      check_eq("bp_accepted",  32'(acc), 32'd5);
      check_eq("bp_in_ready",  32'(bus_a.in_ready_o), 32'h1e);
      check_eq("bp_ovrflw",    32'(bus_a.ovrflw_o),   32'h01);
      check_eq("bp_out_valid", 32'(bus_a.out_valid_o), 32'h08);
      check_eq("bp_out_hold",  32'(bus_a.out_pckt_o[3*c_PW +: c_PW]), 32'(mk(1, 3, 8'h10)));
      bus_a.out_ready_i[3] = 1'b1;
      tick(8);
      check_eq("bp_drain_cnt", 32'(q_out[3].size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         obs = (i < q_out[3].size()) ? q_out[3][i] : 12'hFFF;
         check_eq("bp_drain_order", 32'(obs), 32'(mk(1, 3, 8'h10 + 8'(i))));
      end
      check_eq("bp_ready_back", 32'(bus_a.in_ready_o), 32'h1f);

      // Out-of-mesh drops on the 3x3 router, 2-bit saturating counter
      send(1'b1, 5'b00011, mk(0, 3, 8'h11));
      tick(1);
      check_eq("drop_two", 32'(bus_b.drop_cnt_o), 32'd2);
      send(1'b1, 5'b00100, mk(3, 0, 8'h22));
      tick(1);
      check_eq("drop_row", 32'(bus_b.drop_cnt_o), 32'd3);
      send(1'b1, 5'b00011, mk(0, 3, 8'h33));
      tick(1);
      check_eq("drop_sat", 32'(bus_b.drop_cnt_o), 32'd3);
      tick(2);
      check_eq("drop_silent", 32'(b_seen), 32'd0);
      check_eq("drop_a_zero", 32'(bus_a.drop_cnt_o), 32'd0);
      check_eq("drop_ready",  32'(bus_b.in_ready_o), 32'h1f);
      send(1'b1, 5'b00001, mk(2, 0, 8'h44));
      tick(1);
      check_eq("b_route_down", 32'(bus_b.out_valid_o), 32'h10);
      tick(2);

      // Asynchronous reset with packets buffered and one held in the output stage
      bus_a.out_ready_i[3] = 1'b0;
      bus_a.in_pckt_i[0 +: c_PW] = mk(1, 3, 8'h40);
      bus_a.in_valid_i = 5'b00001;
      tick(3);
      bus_a.in_valid_i = '0;
      tick(1);
      check_eq("pre_rst_valid", 32'(bus_a.out_valid_o), 32'h08);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 32'(bus_a.out_valid_o), 32'h0);
      check_eq("arst_in_ready",  32'(bus_a.in_ready_o),  32'h1f);
      check_eq("arst_ovrflw",    32'(bus_a.ovrflw_o),    32'h0);
      check_eq("arst_drop_b",    32'(bus_b.drop_cnt_o),  32'h0);
      check_eq("arst_out_pckt",  32'(|bus_a.out_pckt_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_a.out_ready_i = '1;
      clear_q();
      tick(8);
      check_eq("arst_no_stale", 32'(q_total()), 32'd0);
      check_eq("arst_idle",     32'(bus_a.out_valid_o), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
